// File: rtl/life_gen_scheduler_if.sv
// Control bundle between the Life generation scheduler and its host, video and compute neighbours.
// The master side is the scheduler; the slave side is everything around it.
interface life_gen_scheduler_if #(
  parameter int ROW_AW = 10,
  parameter int GEN_W  = 16
);
  logic              pause;
  logic              step_req;
  logic              init_active;
  logic              frame_end;
  logic [ROW_AW-1:0] fetch_addr;
  logic              fetch_valid;
  logic [ROW_AW-1:0] calc_row;
  logic              calc_start;
  logic              calc_done;
  logic              src_bank;
  logic              busy;
  logic [GEN_W-1:0]  gen_count;

  modport master (
    input  pause, step_req, init_active, frame_end, calc_done,
    output fetch_addr, fetch_valid, calc_row, calc_start, src_bank, busy, gen_count
  );

  modport slave (
    output pause, step_req, init_active, frame_end, calc_done,
    input  fetch_addr, fetch_valid, calc_row, calc_start, src_bank, busy, gen_count
  );
endinterface

// File: rtl/life_gen_scheduler.sv
// Sequences one Game-of-Life generation: primes the line buffer, walks every row through the
// next-state engine, then flips the source bank only at a frame boundary so video never tears.
module life_gen_scheduler #(
  parameter int Y_SIZE    = 720,
  parameter int ROW_AW    = 10,
  parameter int FETCH_LAT = 2,
  parameter int GEN_W     = 16
) (
  input  logic                 out_stream_aclk,
  input  logic                 periph_reset,
  life_gen_scheduler_if.master bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_PRIME     = 3'd1;
  localparam logic [2:0] ST_CALC      = 3'd2;
  localparam logic [2:0] ST_FETCH     = 3'd3;
  localparam logic [2:0] ST_WAIT_SWAP = 3'd4;
  localparam logic [2:0] ST_SWAP      = 3'd5;

  localparam int               LAT_W     = $clog2(FETCH_LAT + 2);
  localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(FETCH_LAT);
  localparam logic [ROW_AW-1:0] ROW_LAST  = ROW_AW'(Y_SIZE - 1);
  localparam logic [ROW_AW-1:0] ROW_COUNT = ROW_AW'(Y_SIZE);

  logic [2:0]        state;
  logic [ROW_AW-1:0] row_r;
  logic [1:0]        prime_idx;
  logic [LAT_W-1:0]  lat_cnt;
  logic              fetch_valid;
  logic              calc_start;
  logic              src_bank;
  logic [ROW_AW-1:0] fetch_addr;
  logic [ROW_AW-1:0] calc_row;
  logic [GEN_W-1:0]  gen_count;

  logic              start_ok;
  logic              lat_done;
  logic [ROW_AW-1:0] row_ahead;
  logic [ROW_AW-1:0] row_wrap;
  logic [ROW_AW-1:0] row_next;

  always_comb begin
    start_ok  = !bus.init_active && (!bus.pause || bus.step_req);
    lat_done  = (lat_cnt == LAT_LAST);
    row_ahead = row_r + ROW_AW'(2);
    // Toroidal wrap: row_ahead never exceeds Y_SIZE, so one conditional subtract suffices.
    row_wrap  = (row_ahead >= ROW_COUNT) ? (row_ahead - ROW_COUNT) : row_ahead;
    row_next  = row_r + ROW_AW'(1);
  end

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      state       <= ST_IDLE;
      row_r       <= '0;
      prime_idx   <= '0;
      lat_cnt     <= '0;
      fetch_valid <= 1'b0;
      calc_start  <= 1'b0;
      fetch_addr  <= '0;
      calc_row    <= '0;
      src_bank    <= 1'b0;
      gen_count   <= '0;
    end else begin
      fetch_valid <= 1'b0;
      calc_start  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_ok) begin
            state       <= ST_PRIME;
            fetch_valid <= 1'b1;
            fetch_addr  <= ROW_LAST;
            prime_idx   <= '0;
            lat_cnt     <= '0;
          end
        end
        // Three priming fetches (last row, row 0, row 1) fill the 3-row window around row 0.
        ST_PRIME: begin
          if (lat_done) begin
            if (prime_idx == 2'd2) begin
              state      <= ST_CALC;
              row_r      <= '0;
              calc_row   <= '0;
              calc_start <= 1'b1;
            end else begin
              prime_idx   <= prime_idx + 2'd1;
              fetch_valid <= 1'b1;
              fetch_addr  <= (prime_idx == 2'd0) ? '0 : ROW_AW'(1);
              lat_cnt     <= '0;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        ST_CALC: begin
          if (bus.calc_done) begin
            if (row_r == ROW_LAST) begin
              state <= ST_WAIT_SWAP;
            end else begin
              state       <= ST_FETCH;
              fetch_valid <= 1'b1;
              fetch_addr  <= row_wrap;
              lat_cnt     <= '0;
            end
          end
        end
        ST_FETCH: begin
          if (lat_done) begin
            state      <= ST_CALC;
            row_r      <= row_next;
            calc_row   <= row_next;
            calc_start <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        // Bank flip and count bump land on entry to SWAP; SWAP itself just returns to IDLE.
        ST_WAIT_SWAP: begin
          if (bus.frame_end) begin
            state     <= ST_SWAP;
            src_bank  <= ~src_bank;
            gen_count <= gen_count + GEN_W'(1);
          end
        end
        ST_SWAP: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.fetch_addr  = fetch_addr;
  assign bus.fetch_valid = fetch_valid;
  assign bus.calc_row    = calc_row;
  assign bus.calc_start  = calc_start;
  assign bus.src_bank    = src_bank;
  assign bus.gen_count   = gen_count;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: doc/life_gen_scheduler.md
LIFE_GEN_SCHEDULER -- requirements
Module: life_gen_scheduler

Interface
REQ-001 Parameter Y_SIZE, default 720, meaning rows per grid generation.
REQ-002 Parameter ROW_AW, default 10, meaning row address width.
REQ-003 Parameter FETCH_LAT, default 2, meaning wait cycles after each fetch_valid pulse before the next action, covering BRAM read plus line-buffer register.
REQ-004 Parameter GEN_W, default 16, meaning generation counter width.
REQ-005 One clock and one reset: out_stream_aclk, synchronous, active-high periph_reset.
REQ-006 out_stream_aclk  in  1  sole clock; all state updates on its rising edge.
REQ-007 periph_reset  in  1  synchronous, active-high reset.
REQ-008 pause  in  1  level; while high, no new generation starts.
REQ-009 step_req  in  1  one-cycle pulse; starts exactly one generation while paused.
REQ-010 init_active  in  1  host grid initialisation in progress; blocks generation start.
REQ-011 frame_end  in  1  one-cycle pulse from the video path at the last pixel of a frame.
REQ-012 fetch_addr  out  ROW_AW  row the line buffer loads from the source bank.
REQ-013 fetch_valid  out  1  one-cycle pulse; fetch_addr is valid.
REQ-014 calc_row  out  ROW_AW  row the next-state engine computes and writes to the destination bank.
REQ-015 calc_start  out  1  one-cycle pulse; calc_row is valid.
REQ-016 calc_done  in  1  one-cycle pulse; engine has written calc_row.
REQ-017 src_bank  out  1  bank read by video and compute (0 = A, 1 = B); destination is ~src_bank.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 gen_count  out  GEN_W  completed generations; wraps modulo 2^GEN_W.

Function
REQ-020 States: IDLE, PRIME, CALC, FETCH, WAIT_SWAP, SWAP.
REQ-021 IDLE -> PRIME when init_active = 0 and (pause = 0 or step_req = 1); otherwise stay in IDLE.
REQ-022 step_req is ignored outside IDLE, ignored while pause = 0, and ignored while init_active = 1; it is never queued.
REQ-023 PRIME issues three fetches in order: rows Y_SIZE-1, 0, 1 (toroidal wrap).
REQ-024 Each fetch is one fetch_valid cycle followed by exactly FETCH_LAT cycles with fetch_valid low.
REQ-025 PRIME -> CALC with row counter r = 0 after the third fetch wait completes.
REQ-026 On CALC entry: calc_start pulses one cycle with calc_row = r; then wait for calc_done with no timeout.
REQ-027 calc_done outside the CALC wait is ignored.
REQ-028 On calc_done with r < Y_SIZE-1: go to FETCH, fetch row (r+2) mod Y_SIZE, then r <= r+1 and return to CALC.
REQ-029 On calc_done with r = Y_SIZE-1: go to WAIT_SWAP.
REQ-030 frame_end in any state except WAIT_SWAP is ignored, so the display never shows a partial generation.
REQ-031 frame_end arriving in the same cycle as the final calc_done is also ignored.
REQ-032 WAIT_SWAP -> SWAP on frame_end.
REQ-033 SWAP lasts one cycle: toggle src_bank, increment gen_count, go to IDLE.
REQ-034 Asserting pause or init_active mid-generation does not abort it; pause only gates the start in IDLE.
REQ-035 Row arithmetic is ROW_AW bits wide; (r+2) mod Y_SIZE uses compare-and-subtract, not a divider.
REQ-036 fetch_valid and calc_start are never high in the same cycle.

Reset
REQ-037 While periph_reset = 1 at a clock edge, the next state is: state = IDLE, r = 0, src_bank = 0, gen_count = 0, busy = 0, fetch_valid = 0, calc_start = 0, fetch_addr = 0, calc_row = 0.
REQ-038 Reset mid-generation discards all progress; the first generation after reset starts from PRIME.

Verification
REQ-039 Scenario 1: after reset, pause = 0, init_active = 0, calc_done returned 3 cycles after each calc_start -> fetch_addr sequence is 719, 0, 1, 2, ..., 719, 0; calc_row sequence is 0..719; fetch_valid pulses spaced FETCH_LAT+1 cycles apart during PRIME.
REQ-040 Scenario 2: generation finishes, then frame_end 100 cycles later -> src_bank 0 -> 1 and gen_count 0 -> 1 exactly one cycle after frame_end; busy falls one cycle after that.
REQ-041 Scenario 3: frame_end pulsed during CALC at r = 300 and again in the cycle of the final calc_done -> no swap; swap occurs only on the next frame_end.
REQ-042 Scenario 4: pause = 1, two step_req pulses 10 cycles apart -> exactly one generation runs and gen_count = 1 after the swap; step_req while init_active = 1 -> busy stays 0.
REQ-043 Scenario 5: periph_reset pulsed while in CALC at r = 500 with src_bank = 1 and gen_count = 7 -> next cycle: src_bank = 0, gen_count = 0, busy = 0; a restart begins with fetch_addr = 719.
REQ-044 Scenario 6: gen_count at 16'hFFFF, one full generation with swap -> gen_count = 16'h0000.
